irq_dispatcher: RTL and testbench

//  Master-side servicer for the interrupt controller register port. On a consolidated IRQ it

---
 rtl/irq_dispatcher.sv | 167 ++++++++++++++++
 tb/tb_irq_dispatcher.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_dispatcher.sv
// irq_dispatcher: services the interrupt controller's STATUS register on a
// consolidated IRQ. It hands pending sources to the sequencer one at a time,
// lowest index first, and issues a W1C for each source after it is accepted.
//
// Optional build macro: IRQ_DISP_TIMEOUT_EN. When it is defined, a stuck
// consumer is given up on after TIMEOUT dispatch cycles and the source is
// cleared anyway.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for irq_in while enabled
// READ     | STATUS address driven; pending mask latched at the clock edge
// DISPATCH | vector offered to the consumer, waiting for ready
// CLEAR    | W1C of the dispatched source, then next vector or IDLE
module irq_dispatcher #(
  parameter int                    NUM_IRQS    = 32,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = '0,
  parameter int                    TIMEOUT     = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_irq_in,
  output logic                  o_reg_wr,
  output logic [ADDR_WIDTH-1:0] o_reg_addr,
  output logic [DATA_WIDTH-1:0] o_reg_wdata,
  input  logic [DATA_WIDTH-1:0] i_reg_rdata,
  output logic                  o_vec_valid,
  output logic [((NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1)-1:0] o_vec_id,
  input  logic                  i_vec_ready,
  output logic                  o_busy,
  output logic                  o_timeout_err
);

  localparam int IDW = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ     = 2'd1,
    DISPATCH = 2'd2,
    CLEAR    = 2'd3
  } state_t;

  state_t                r_state;
  logic [NUM_IRQS-1:0]   r_mask;
  logic                  r_reg_wr;
  logic [ADDR_WIDTH-1:0] r_reg_addr;
  logic [DATA_WIDTH-1:0] r_reg_wdata;
  logic                  r_vec_valid;
  logic [IDW-1:0]        r_vec_id;

  logic [NUM_IRQS-1:0]   w_rd_mask;
  logic                  w_hs;
  logic                  w_tmo;
  logic                  w_unused_rdata;

  // Status bits above the implemented sources are deliberately ignored.
  assign w_rd_mask      = i_reg_rdata[NUM_IRQS-1:0];
  assign w_unused_rdata = &{1'b0, i_reg_rdata};
  assign w_hs           = r_vec_valid && i_vec_ready;

`ifdef IRQ_DISP_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TW-1:0] r_tmo_cnt;
  logic          r_tmo_err;

  // The last cycle without ready is the TIMEOUT-th DISPATCH cycle.
  assign w_tmo         = (r_state == DISPATCH) && !w_hs && (r_tmo_cnt == TW'(TIMEOUT - 1));
  assign o_timeout_err = r_tmo_err;
`else
  assign w_tmo         = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  // Lowest set bit wins.
  function automatic logic [IDW-1:0] f_lowest(input logic [NUM_IRQS-1:0] m);
    f_lowest = '0;
    for (int i = NUM_IRQS - 1; i >= 0; i--) begin
      if (m[i]) f_lowest = IDW'(i);
    end
  endfunction

  // Sequencing FSM; every output is registered here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_mask      <= '0;
      r_reg_wr    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_vec_valid <= 1'b0;
      r_vec_id    <= '0;
`ifdef IRQ_DISP_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      r_tmo_err   <= 1'b0;
`endif
    end else begin
      r_reg_wr    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
`ifdef IRQ_DISP_TIMEOUT_EN
      r_tmo_err   <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (i_irq_in && i_enable) begin
            r_state    <= READ;
            r_reg_addr <= STATUS_ADDR;
          end
        end
        READ: begin
          r_mask <= w_rd_mask;
          if (w_rd_mask == '0) begin
            r_state <= IDLE;
          end else begin
            r_state     <= DISPATCH;
            r_vec_valid <= 1'b1;
            r_vec_id    <= f_lowest(w_rd_mask);
`ifdef IRQ_DISP_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
          end
        end
        DISPATCH: begin
          if (w_hs || w_tmo) begin
            // Mask bit drops here so CLEAR can decide on the remainder.
            r_state     <= CLEAR;
            r_vec_valid <= 1'b0;
            r_reg_wr    <= 1'b1;
            r_reg_addr  <= STATUS_ADDR;
            r_reg_wdata <= DATA_WIDTH'(1) << r_vec_id;
            r_mask      <= r_mask & ~(NUM_IRQS'(1) << r_vec_id);
`ifdef IRQ_DISP_TIMEOUT_EN
            r_tmo_err   <= w_tmo;
          end else begin
            r_tmo_cnt   <= r_tmo_cnt + TW'(1);
`endif
          end
        end
        CLEAR: begin
          if ((r_mask != '0) && i_enable) begin
            r_state     <= DISPATCH;
            r_vec_valid <= 1'b1;
            r_vec_id    <= f_lowest(r_mask);
`ifdef IRQ_DISP_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_reg_wr    = r_reg_wr;
  assign o_reg_addr  = r_reg_addr;
  assign o_reg_wdata = r_reg_wdata;
  assign o_vec_valid = r_vec_valid;
  assign o_vec_id    = r_vec_id;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_irq_dispatcher.sv
// Directed bench for irq_dispatcher: a STATUS register model with W1C, plus
// hand-computed expectations for each scenario.
module tb_irq_dispatcher;

  localparam logic [7:0] SA = 8'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        irq_force;
  logic        irq_in;
  logic        reg_wr;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        vec_valid;
  logic [4:0]  vec_id;
  logic        vec_ready;
  logic        busy;
  logic        timeout_err;
  logic [31:0] status;

  int          n_cmp = 0;
  int          n_err = 0;
  int          hs_q[$];
  logic [31:0] wr_q[$];
  int          b2b, terr_cnt, valid_cyc;

  always #5 clk = ~clk;

  assign irq_in    = (|status) | irq_force;
  assign reg_rdata = (reg_addr == SA) ? status : 32'hDEAD_BEEF;

  irq_dispatcher #(
    .NUM_IRQS   (32),
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .STATUS_ADDR(SA),
    .TIMEOUT    (8)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (enable),
    .i_irq_in     (irq_in),
    .o_reg_wr     (reg_wr),
    .o_reg_addr   (reg_addr),
    .o_reg_wdata  (reg_wdata),
    .i_reg_rdata  (reg_rdata),
    .o_vec_valid  (vec_valid),
    .o_vec_id     (vec_id),
    .i_vec_ready  (vec_ready),
    .o_busy       (busy),
    .o_timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    hs_q.delete();
    wr_q.delete();
    b2b       = 0;
    terr_cnt  = 0;
    valid_cyc = 0;
  endtask

  // Record this cycle's activity, apply any W1C to the model, advance one clock.
  task automatic step();
    if (vec_valid && vec_ready) hs_q.push_back(int'(vec_id));
    if (reg_wr) begin
      wr_q.push_back(reg_wdata);
      if (reg_addr == SA) status = status & ~reg_wdata;
    end
    if (reg_wr && vec_valid) b2b++;
    if (timeout_err) terr_cnt++;
    if (vec_valid) valid_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_idle();
    for (int i = 0; i < 60 && (busy || irq_in); i++) step();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; irq_force = 1'b0; vec_ready = 1'b0; status = '0;
    clr_log();
    step(); step(); step();
    chk("rst_valid", 32'(vec_valid), 0);
    chk("rst_wr", 32'(reg_wr), 0);
    chk("rst_addr", 32'(reg_addr), 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_id", 32'(vec_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    rst = 1'b0; enable = 1'b1;
    step();

    // single source
    clr_log();
    status = 32'h0000_0020; vec_ready = 1'b1;
    step();
    chk("t1_read_addr", 32'(reg_addr), 32'(SA));
    chk("t1_read_valid", 32'(vec_valid), 0);
    step();
    chk("t1_valid", 32'(vec_valid), 1);
    chk("t1_id", 32'(vec_id), 5);
    step();
    chk("t1_wr", 32'(reg_wr), 1);
    chk("t1_wdata", reg_wdata, 32'h20);
    chk("t1_wr_addr", 32'(reg_addr), 32'(SA));
    chk("t1_clr_valid", 32'(vec_valid), 0);
    step();
    chk("t1_idle", 32'(busy), 0);
    chk("t1_idle_addr", 32'(reg_addr), 0);
    chk("t1_idle_wdata", reg_wdata, 0);

    // multiple sources
    clr_log();
    status = 32'h8001_0004;
    step();
    run_to_idle();
    chk("t2_done", status, 0);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_nvec", hs_q.size(), 3);
    chk("t2_v0", hs_q[0], 2);
    chk("t2_v1", hs_q[1], 16);
    chk("t2_v2", hs_q[2], 31);
    chk("t2_nwr", wr_q.size(), 3);
    chk("t2_w0", wr_q[0], 32'h0000_0004);
    chk("t2_w1", wr_q[1], 32'h0001_0000);
    chk("t2_w2", wr_q[2], 32'h8000_0000);
    chk("t2_b2b", b2b, 0);
    // 3 vectors x (DISPATCH + CLEAR) = 6 valid-or-write cycles; valid on 3
    chk("t2_vcyc", valid_cyc, 3);

    // spurious
    clr_log();
    irq_force = 1'b1;
    step();
    chk("t3_busy_read", 32'(busy), 1);
    chk("t3_addr", 32'(reg_addr), 32'(SA));
    irq_force = 1'b0;
    step();
    chk("t3_idle", 32'(busy), 0);
    step(); step(); step();
    chk("t3_novec", valid_cyc, 0);
    chk("t3_nowr", wr_q.size(), 0);

    // backpressure
    clr_log();
    status = 32'h0000_0100; vec_ready = 1'b0;
    step(); step();
    chk("t4_valid", 32'(vec_valid), 1);
    chk("t4_id", 32'(vec_id), 8);
    for (int i = 0; i < 10; i++) step();
    chk("t4_vcyc", valid_cyc, 10);
    chk("t4_id_hold", 32'(vec_id), 8);
    chk("t4_nowr", wr_q.size(), 0);
    vec_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t4_nwr", wr_q.size(), 1);
    chk("t4_w0", wr_q[0], 32'h100);
    chk("t4_busy", 32'(busy), 0);

    // timeout
    clr_log();
    status = 32'h0000_0002; vec_ready = 1'b0;
    step(); step();
    chk("t5_valid", 32'(vec_valid), 1);
    chk("t5_id", 32'(vec_id), 1);
`ifdef IRQ_DISP_TIMEOUT_EN
    valid_cyc = 0;
    for (int i = 0; i < 30 && !reg_wr; i++) step();
    chk("t5_disp_cycles", valid_cyc, 8);
    chk("t5_terr", 32'(timeout_err), 1);
    chk("t5_wr", 32'(reg_wr), 1);
    chk("t5_wdata", reg_wdata, 32'h2);
    chk("t5_valid_drop", 32'(vec_valid), 0);
    step(); step(); step();
    chk("t5_terr_once", terr_cnt, 1);
    chk("t5_busy", 32'(busy), 0);
`else
    for (int i = 0; i < 20; i++) step();
    chk("t5_wait_valid", 32'(vec_valid), 1);
    chk("t5_wait_id", 32'(vec_id), 1);
    chk("t5_no_terr", terr_cnt, 0);
    chk("t5_nowr", wr_q.size(), 0);
    vec_ready = 1'b1;
    step(); step(); step();
    chk("t5_nwr", wr_q.size(), 1);
    chk("t5_w0", wr_q[0], 32'h2);
    chk("t5_busy", 32'(busy), 0);
`endif

    // enable dropped mid-pass
    clr_log();
    status = 32'h0000_0003; vec_ready = 1'b0;
    step(); step();
    chk("t7_id", 32'(vec_id), 0);
    enable = 1'b0; vec_ready = 1'b1;
    step();
    chk("t7_wr", 32'(reg_wr), 1);
    chk("t7_wdata", reg_wdata, 32'h1);
    step();
    chk("t7_idle", 32'(busy), 0);
    step(); step();
    chk("t7_stay_idle", 32'(busy), 0);
    chk("t7_nvec", hs_q.size(), 1);
    enable = 1'b1;
    step();
    run_to_idle();
    chk("t7_resume", status, 0);
    chk("t7_v1", hs_q[1], 1);

    // reset during DISPATCH
    clr_log();
    status = 32'h0000_0004; vec_ready = 1'b0;
    step(); step();
    chk("t6_valid", 32'(vec_valid), 1);
    rst = 1'b1;
    step();
    chk("t6_valid0", 32'(vec_valid), 0);
    chk("t6_wr0", 32'(reg_wr), 0);
    chk("t6_addr0", 32'(reg_addr), 0);
    chk("t6_wdata0", reg_wdata, 0);
    chk("t6_id0", 32'(vec_id), 0);
    chk("t6_busy0", 32'(busy), 0);
    enable = 1'b0; rst = 1'b0; vec_ready = 1'b1;
    clr_log();
    for (int i = 0; i < 6; i++) step();
    chk("t6_nowr", wr_q.size(), 0);
    chk("t6_novec", valid_cyc, 0);
    chk("t6_status_kept", status, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
